// File: rtl/store_buffer_if.sv
// -----------------------------------------------------------------------------
// store_buffer_if
// Bundles the pipeline-side request/response signals and the data-memory
// signals of the store buffer.
//   master : the environment (pipeline + data memory). It drives the request
//            and the combinational memory read data.
//   slave  : the store buffer itself.
// Signals:
//   req_read/req_write/req_address/req_data : pipeline load/store request
//   rd_data/stall/count                     : load result, hold, occupancy
//   mem_read/mem_write/mem_address/mem_wdata: data-memory strobes and bus
//   mem_result                              : combinational memory read data
// -----------------------------------------------------------------------------
interface store_buffer_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          req_read;
    logic          req_write;
    logic [31:0]   req_address;
    logic [31:0]   req_data;
    logic [31:0]   rd_data;
    logic          stall;
    logic [CW-1:0] count;
    logic          mem_read;
    logic          mem_write;
    logic [31:0]   mem_address;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_result;

    modport master (
        output req_read, req_write, req_address, req_data, mem_result,
        input  rd_data, stall, count, mem_read, mem_write, mem_address, mem_wdata
    );

    modport slave (
        input  req_read, req_write, req_address, req_data, mem_result,
        output rd_data, stall, count, mem_read, mem_write, mem_address, mem_wdata
    );
endinterface

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
// FIFO of pending stores sitting between the pipeline and data memory.
// Stores are buffered and written to memory only in cycles where the pipeline
// does not use the memory port (idle or stalled). Loads that match a buffered
// word either forward the youngest matching data or stall until the matching
// stores have drained.
//
// Optional feature macro: STORE_FWD_EN
//   defined   : load hits forward the youngest matching entry, no stall
//   undefined : load hits stall and drain one entry per cycle until no match
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset; discards all buffered stores
//   bus  : store_buffer_if.slave (request, response and memory signals)
// -----------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    store_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

`ifdef STORE_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic [31:0]   r_addr [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_match;
    logic          w_hit;
    logic [31:0]   w_fwd_data;
    logic [PW-1:0] w_idx;
    logic          w_full;
    logic          w_stall;
    logic          w_drain;
    logic          w_push;

    // Scan oldest to youngest starting at the head so the last match seen is
    // the youngest one; valid entries are exactly those between head and tail.
    always_comb begin
        w_match    = 1'b0;
        w_fwd_data = '0;
        w_idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_head + PW'(k);
            if (r_valid[w_idx] && (r_addr[w_idx][31:2] == bus.req_address[31:2])) begin
                w_match    = 1'b1;
                w_fwd_data = r_data[w_idx];
            end
        end
    end

    assign w_hit   = bus.req_read & w_match;
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_stall = (bus.req_write & w_full) | (w_hit & ~FWD_EN);
    // The memory port is free only when the pipeline is idle or stalled, so a
    // push and a pop never happen on the same edge.
    assign w_drain = (r_count != '0) & ((~bus.req_read & ~bus.req_write) | w_stall);
    assign w_push  = bus.req_write & ~w_stall;

    assign bus.stall       = w_stall;
    assign bus.count       = r_count;
    assign bus.mem_write   = w_drain;
    assign bus.mem_read    = bus.req_read & ~w_hit;
    assign bus.mem_address = w_drain ? r_addr[r_head] : bus.req_address;
    assign bus.mem_wdata   = w_drain ? r_data[r_head] : '0;

    always_comb begin
        bus.rd_data = '0;
        if (!w_stall && bus.req_read) begin
            if (!w_hit)
                bus.rd_data = bus.mem_result;
            else if (FWD_EN)
                bus.rd_data = w_fwd_data;
        end
    end

    // Entry payload needs no reset: the valid bits alone decide occupancy.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= bus.req_address;
            r_data[r_tail] <= bus.req_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PW'(1);
            end
            if (w_drain) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_drain);
        end
    end
endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL have parameter DEPTH, 4, number of buffered stores (power of two, 2..16).
REQ-003 Port clk  input  1  clock; all state updates occur on its rising edge.
REQ-004 Port rst  input  1  asynchronous active-low reset.
REQ-005 Port req_read  input  1  pipeline load request; never asserted together with req_write.
REQ-006 Port req_write  input  1  pipeline store request.
REQ-007 Port req_address  input  32  byte address of the request; word index is bits [31:2].
REQ-008 Port req_data  input  32  store data.
REQ-009 Port rd_data  output  32  load result.
REQ-010 Port stall  output  1  pipeline must hold its request for another cycle.
REQ-011 Port count  output  clog2(DEPTH)+1  number of occupied entries.
REQ-012 Ports mem_read / mem_write  output  1 each  data-memory strobes.
REQ-013 Ports mem_address / mem_wdata  output  32 each  data-memory address and write data.
REQ-014 Port mem_result  input  32  combinational data-memory read data.

Function
REQ-015 The block SHALL hold up to DEPTH stores (address, data) in FIFO order, with head and tail pointers wrapping modulo DEPTH.
REQ-016 hit SHALL be 1 when req_read=1 and any occupied entry has address[31:2] equal to req_address[31:2].
REQ-017 stall SHALL be (req_write & count==DEPTH) | (req_read & hit & no-forwarding config), combinationally.
REQ-018 drain SHALL be count>0 & ((req_read==0 & req_write==0) | stall).
REQ-019 When drain=1: mem_write=1, mem_address=head address, mem_wdata=head data, and the head is popped at the next edge.
REQ-020 When drain=0: mem_write=0, mem_address=req_address, mem_wdata=0.
REQ-021 mem_read SHALL be req_read & !hit.
REQ-022 A store with stall=0 SHALL be pushed at the tail at the next edge; with stall=1 it SHALL NOT be pushed.
REQ-023 Push and pop in the same edge cannot coincide (drain requires no request or stall); count changes by exactly +1, -1 or 0.
REQ-024 rd_data SHALL be mem_result when req_read & !hit, forwarded data when req_read & hit with forwarding, and 0 otherwise (including stall).
REQ-025 Load latency SHALL be zero cycles: rd_data is valid in the request cycle unless stall=1.
REQ-026 A full buffer with a store pending SHALL drain one entry in the stall cycle, then accept the store the next cycle.
REQ-027 Duplicate addresses SHALL be kept as separate entries and drained in order, so the younger value lands last.

Reset
REQ-028 While rst=0, count, head and tail SHALL be 0 and all entries invalid, asynchronously.
REQ-029 Stores still buffered when reset asserts SHALL be discarded, never written to memory.
REQ-030 Out of reset with no request: stall=0, mem_read=0, mem_write=0, rd_data=0, mem_wdata=0.

Configuration
REQ-031 With STORE_FWD_EN defined: on hit, rd_data SHALL be the data of the youngest matching entry, stall=0, mem_read=0.
REQ-032 Without STORE_FWD_EN: on hit, stall SHALL be 1 and the buffer drains one entry per cycle until no match remains; the load then reads memory.

Verification
REQ-033 Reset, 4 stores (0x00..0x0C, data 1..4), no idle cycles -> count=4, mem_write never 1, stall=0.
REQ-034 Full buffer + store to 0x10 -> stall=1 one cycle with mem_write=1 at 0x00 data 1, store accepted next cycle, count=4.
REQ-035 Stores 0x20=A then 0x20=B, load 0x22, STORE_FWD_EN -> rd_data=B, mem_read=0, stall=0.
REQ-036 Same stimulus without STORE_FWD_EN -> stall 2 cycles draining A then B, then mem_read=1, rd_data=B from memory.
REQ-037 3 stores then 3 idle cycles -> memory writes in push order, count 3->0, pointers wrap correctly on next 4 stores.
REQ-038 rst low while count=2 -> count=0 immediately, no further mem_write, memory unchanged.
